// File: rtl/proc_pkg.sv
// Types and constants shared by the fetch stage and the decode/control logic.
package proc_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef logic [DW_DEF-1:0] instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_FULL = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the PC, reads instruction memory with a
// req/ready handshake, holds the word in the IR until decode acks it.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          fetch_en,
    input  logic          flush,
    input  logic [AW-1:0] pc_in,
    output logic          incr_pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir_out,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ack,
    output logic          busy
);

    fetch_state_t  state, state_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] ir_nx;
    logic [AW-1:0] ir_pc_nx;
    logic          incr_nx;

    // Next-state and next-register values; flush overrides everything.
    always_comb begin
        state_nx = state;
        addr_nx  = mem_addr;
        ir_nx    = ir_out;
        ir_pc_nx = ir_pc;
        incr_nx  = 1'b0;
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_en) begin
                        state_nx = ST_REQ;
                        addr_nx  = pc_in;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        state_nx = ST_FULL;
                        ir_nx    = mem_rdata;
                        ir_pc_nx = mem_addr;
                        incr_nx  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (ir_ack) begin
                        if (fetch_en) begin
                            state_nx = ST_REQ;
                            addr_nx  = pc_in;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake flags are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mem_req  <= 1'b0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
            incr_pc  <= 1'b0;
        end else begin
            mem_req  <= (state_nx == ST_REQ);
            ir_valid <= (state_nx == ST_FULL);
            busy     <= (state_nx != ST_IDLE);
            incr_pc  <= incr_nx;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mem_addr <= '0;
            ir_out   <= '0;
            ir_pc    <= '0;
        end else begin
            mem_addr <= addr_nx;
            ir_out   <= ir_nx;
            ir_pc    <= ir_pc_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corner
// cases, and a randomized run against a transaction-level reference model.
module tb_fetch_unit;
    import proc_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clock = 1'b0;
    logic        resetN;
    logic        fetch_en;
    logic        flush;
    logic [15:0] pc_in;
    logic        incr_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    instr_t      mem_rdata;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.AW(16), .DW(16)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .pc_in     (pc_in),
        .incr_pc   (incr_pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ack    (ir_ack),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        fe, fl, rdy, ack;
        logic [15:0] rdata;
        logic        req;
        logic [15:0] addr;
        logic        incr, valid;
        logic [15:0] ir, irpc;
        logic        bsy;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic fe, input logic fl, input logic rdy,
                                input logic ack, input logic [15:0] rdata,
                                input logic req, input logic [15:0] addr,
                                input logic incr, input logic valid,
                                input logic [15:0] ir, input logic [15:0] irpc,
                                input logic bsy);
        vec_t v;
        v.fe = fe; v.fl = fl; v.rdy = rdy; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.incr = incr; v.valid = valid;
        v.ir = ir; v.irpc = irpc; v.bsy = bsy;
        return v;
    endfunction

    // Reference model: one outstanding request or one held instruction.
    logic        model_on = 1'b0;
    logic        m_req, m_full, m_incr;
    logic [15:0] m_addr, m_ir, m_irpc;

    task automatic model_reset();
        m_req = 1'b0; m_full = 1'b0; m_incr = 1'b0;
        m_addr = 16'h0; m_ir = 16'h0; m_irpc = 16'h0;
    endtask

    task automatic model_step();
        m_incr = 1'b0;
        if (flush) begin
            m_req  = 1'b0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (ir_ack) begin
                m_full = 1'b0;
                if (fetch_en) begin
                    m_req  = 1'b1;
                    m_addr = pc_in;
                end
            end
        end else if (m_req) begin
            if (mem_ready) begin
                m_req  = 1'b0;
                m_full = 1'b1;
                m_ir   = mem_rdata;
                m_irpc = m_addr;
                m_incr = 1'b1;
            end
        end else if (fetch_en) begin
            m_req  = 1'b1;
            m_addr = pc_in;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                           input logic incr, input logic valid, input logic [15:0] ir,
                           input logic [15:0] irpc, input logic bsy);
        chk({tag, ".mem_req"},  {31'd0, mem_req},  {31'd0, req});
        chk({tag, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        chk({tag, ".incr_pc"},  {31'd0, incr_pc},  {31'd0, incr});
        chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, valid});
        chk({tag, ".ir_out"},   {16'd0, ir_out},   {16'd0, ir});
        chk({tag, ".ir_pc"},    {16'd0, ir_pc},    {16'd0, irpc});
        chk({tag, ".busy"},     {31'd0, busy},     {31'd0, bsy});
    endtask

    // The PC advances on the falling edge of an incr_pc cycle unless it is being loaded.
    task automatic tick();
        @(negedge clock);
        if (incr_pc && !flush) pc_in = pc_in + 16'd1;
        if (model_on) model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; fetch_en = 1'b0; flush = 1'b0;
        mem_ready = 1'b0; ir_ack = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset", L, 16'h0, L, L, 16'h0, 16'h0, L);
        resetN = 1'b1;
        model_reset();
    endtask

    initial begin
        pc_in = 16'h0;
        vt[0]  = mk(H, L, H, L, 16'hA5A5, H, 16'd4, L, L, 16'h0000, 16'd0, H);
        vt[1]  = mk(H, L, H, L, 16'hA5A5, L, 16'd4, H, H, 16'hA5A5, 16'd4, H);
        vt[2]  = mk(H, L, H, H, 16'hBEEF, H, 16'd5, L, L, 16'hA5A5, 16'd4, H);
        vt[3]  = mk(H, L, L, L, 16'hBEEF, H, 16'd5, L, L, 16'hA5A5, 16'd4, H);
        vt[4]  = mk(H, L, L, L, 16'hBEEF, H, 16'd5, L, L, 16'hA5A5, 16'd4, H);
        vt[5]  = mk(H, L, L, L, 16'hBEEF, H, 16'd5, L, L, 16'hA5A5, 16'd4, H);
        vt[6]  = mk(H, L, H, L, 16'hBEEF, L, 16'd5, H, H, 16'hBEEF, 16'd5, H);
        for (int i = 7; i < 12; i++)
            vt[i] = mk(H, L, H, L, 16'h0000, L, 16'd5, L, H, 16'hBEEF, 16'd5, H);
        vt[12] = mk(H, L, H, H, 16'h0000, H, 16'd6, L, L, 16'hBEEF, 16'd5, H);
        vt[13] = mk(H, H, H, L, 16'h1234, L, 16'd6, L, L, 16'hBEEF, 16'd5, L);
        vt[14] = mk(H, L, H, L, 16'h1234, H, 16'd6, L, L, 16'hBEEF, 16'd5, H);
        vt[15] = mk(H, L, H, L, 16'hCAFE, L, 16'd6, H, H, 16'hCAFE, 16'd6, H);
        vt[16] = mk(H, H, H, H, 16'h5555, L, 16'd6, L, L, 16'hCAFE, 16'd6, L);
        vt[17] = mk(L, L, H, H, 16'h5555, L, 16'd6, L, L, 16'hCAFE, 16'd6, L);

        do_reset();
        pc_in = 16'd4;
        for (int i = 0; i < 18; i++) begin
            fetch_en  = vt[i].fe;
            flush     = vt[i].fl;
            mem_ready = vt[i].rdy;
            ir_ack    = vt[i].ack;
            mem_rdata = vt[i].rdata;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].incr,
                    vt[i].valid, vt[i].ir, vt[i].irpc, vt[i].bsy);
        end

        // Asynchronous reset between edges while a request is outstanding.
        fetch_en = 1'b1; flush = 1'b0; mem_ready = 1'b0; ir_ack = 1'b0;
        tick();
        chk("async.pre_req", {31'd0, mem_req}, 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        chk_all("async", L, 16'h0, L, L, 16'h0, 16'h0, L);
        fetch_en = 1'b0;
        @(posedge clock);
        #1;
        chk_all("async.hold", L, 16'h0, L, L, 16'h0, 16'h0, L);
        resetN = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        pc_in = 16'($urandom);
        model_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            fetch_en  = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 99) < 7);
            mem_ready = $urandom_range(0, 1) == 1;
            ir_ack    = $urandom_range(0, 1) == 1;
            mem_rdata = 16'($urandom);
            if (flush) pc_in = 16'($urandom);
            tick();
            chk_all("rand", m_req, m_addr, m_incr, m_full, m_ir, m_irpc, m_req | m_full);
        end
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program counter and the decode/control logic. It samples the current PC value, runs a request/ready handshake to instruction memory, latches the returned word into the instruction register (IR), and pulses the PC's `incr_pc` input once per fetched instruction. Decode consumes the IR through a valid/ack handshake, and a flush input discards in-flight work when the PC is reloaded by a jump or branch.

## Interface
- `AW`, default 16: address width; matches the PC width.
- `DW`, default 16: instruction width.

- `clock` input 1: single clock; all flops on rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `fetch_en` input 1: control requests that instructions be fetched.
- `flush` input 1: the PC is being loaded this cycle; abandon current fetch.
- `pc_in` input AW: current PC value (PC `out`).
- `incr_pc` output 1: to PC `incr_pc`; one-cycle pulse per accepted instruction.
- `mem_req` output 1: instruction memory read request.
- `mem_addr` output AW: read address; stable while `mem_req`=1.
- `mem_ready` input 1: memory returns `mem_rdata` this cycle.
- `mem_rdata` input DW: instruction word.
- `ir_out` output DW: instruction register contents.
- `ir_pc` output AW: address the IR word was fetched from.
- `ir_valid` output 1: IR holds an unconsumed instruction.
- `ir_ack` input 1: decode consumes IR (meaningful only with `ir_valid`=1).
- `busy` output 1: state is not IDLE.

## Operation
- States: IDLE, REQ, FULL. Encoding is a shared constant.
- IDLE: `fetch_en`=1 -> REQ; latch `mem_addr <= pc_in`.
- REQ: `mem_req`=1. `mem_ready`=1 -> `ir_out <= mem_rdata`, `ir_pc <= mem_addr`, `incr_pc`=1 for the next cycle only, -> FULL. `mem_ready`=0 -> stay; address held.
- FULL: `ir_valid`=1. `ir_ack`=1 with `fetch_en`=1 -> REQ, latch `mem_addr <= pc_in`. `ir_ack`=1 with `fetch_en`=0 -> IDLE. `ir_ack`=0 -> stay; `ir_out` and `ir_pc` held.
- `flush`=1, any state -> IDLE. `ir_valid`, `mem_req` and `incr_pc` go 0 next cycle. Flush has priority over `mem_ready` and `ir_ack`. Data returning in a flush cycle is discarded and `incr_pc` is not pulsed.
- `fetch_en` deasserting in REQ does not cancel the request; only `flush` does.
- No address arithmetic is done here. Wrap of `pc_in` is the PC's concern, and `mem_addr` is a plain copy.
- `incr_pc` and `load` on the PC must never be requested together. Flush suppresses any pending `incr_pc` pulse.

## Timing
- Reset values (async, `resetN`=0): state IDLE; `mem_req`=0, `mem_addr`=0, `incr_pc`=0, `ir_out`=0, `ir_pc`=0, `ir_valid`=0, `busy`=0.
- Reset mid-REQ drops `mem_req` immediately (asynchronously).
- All outputs are registered.
- `fetch_en` sampled at edge N in IDLE -> `mem_req`=1 from N to N+1.
- `mem_ready` sampled at edge M -> `ir_valid`=1 and `incr_pc`=1 from M. `incr_pc` returns to 0 at M+1.
- The PC updates on the falling edge inside the `incr_pc` cycle, so `pc_in` is valid at edge M+1.
- `ir_ack` at edge K -> `ir_valid`=0 from K; with `fetch_en`, `mem_req`=1 from K.
- Zero-wait memory sustains 1 instruction per 2 cycles when decode acks on the first valid cycle.
- `flush` at edge F -> all request/valid outputs are 0 from F.

## Structure
- Shared package `proc_pkg`: state encoding (IDLE/REQ/FULL), `AW`/`DW` defaults, and the instruction-word type shared with decode.
- Single module with no sub-module. The IR/ir_pc register pair is small enough to stay inline.

## Test plan
- Zero-wait fetch: reset, `pc_in`=4, `fetch_en`=1, `mem_ready` tied 1, `mem_rdata`=16'hA5A5. Expect `mem_addr`=4, then `ir_out`=16'hA5A5, `ir_pc`=4, `ir_valid`=1, a single `incr_pc` pulse, and `pc_in`=5 at the next request.
- Wait states: hold `mem_ready`=0 for 3 cycles. Expect `mem_req`=1 and `mem_addr` stable for 4 cycles, exactly one `incr_pc`, and no `ir_valid` before `mem_ready`.
- Decode backpressure: `ir_ack`=0 for 5 cycles in FULL. Expect `ir_out`/`ir_pc` held, no new `mem_req`, and no extra `incr_pc`. On ack, a new request to `pc_in`=5.
- Flush with ready: `flush`=1 and `mem_ready`=1 on the same edge with `mem_rdata`=16'h1234. Expect the IR unchanged, `ir_valid`=0, no `incr_pc`, and state IDLE.
- Flush in FULL with `ir_ack`=1: expect IDLE, `ir_valid`=0, and no request issued that cycle.
- Async reset mid-REQ: drive `resetN` low between edges. Expect `mem_req`=0 immediately and all outputs at reset values.
